// File: rtl/i2c_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : i2c_master_ctrl
// Purpose  : I2C master for one register write or register read per request
// Revision : 1.0 - initial release
// ============================================================================
module i2c_master_ctrl #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wr_data,
  output logic       scl,
  output logic       sda_out,
  input  logic       sda_in,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rd_data
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_START, ST_DEV_W, ST_ACK1, ST_REG, ST_ACK2, ST_WDATA,
    ST_ACK3, ST_RESTART, ST_DEV_R, ST_ACK4, ST_RDATA, ST_MNACK, ST_STOP
  } state_t;

  localparam logic [7:0] c_pre_max = 8'(CLK_DIV - 1);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_pre;
  logic [1:0] r_q;
  logic [2:0] r_bit;
  logic       r_rw;
  logic [6:0] r_dev;
  logic [7:0] r_reg;
  logic [7:0] r_wd;
  logic [7:0] r_shift;
  logic       r_done;
  logic       r_ack_err;
  logic [7:0] r_rd;

  logic       w_q_end;
  logic       w_slot_end;
  logic       w_byte_end;
  logic       w_sample;
  logic       w_bit_state;
  logic       w_ack_state;
  logic       w_nack;
  logic [7:0] w_tx_byte;
  logic       w_scl;
  logic       w_sda;

  assign w_q_end     = (r_pre == c_pre_max);
  assign w_slot_end  = w_q_end && (r_q == 2'd3);
  assign w_byte_end  = w_slot_end && (r_bit == 3'd0);
  assign w_sample    = (r_q == 2'd3) && (r_pre == 8'd0);
  assign w_bit_state = (r_state == ST_DEV_W) || (r_state == ST_REG) ||
                       (r_state == ST_WDATA) || (r_state == ST_DEV_R) ||
                       (r_state == ST_RDATA);
  assign w_ack_state = (r_state == ST_ACK1) || (r_state == ST_ACK2) ||
                       (r_state == ST_ACK3) || (r_state == ST_ACK4);
  // With CLK_DIV = 1 the sample cycle is also the slot's last cycle,
  // so the live sda_in must take part in the branch decision.
  assign w_nack      = r_ack_err || (w_sample && sda_in);

  always_comb begin
    w_next    = r_state;
    w_scl     = 1'b1;
    w_sda     = 1'b1;
    w_tx_byte = 8'hFF;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_START;
      end
      ST_START: begin
        w_sda = ~r_q[1];
        if (w_slot_end) w_next = ST_DEV_W;
      end
      ST_DEV_W, ST_REG, ST_WDATA, ST_DEV_R: begin
        case (r_state)
          ST_DEV_W: w_tx_byte = {r_dev, 1'b0};
          ST_REG:   w_tx_byte = r_reg;
          ST_WDATA: w_tx_byte = r_wd;
          default:  w_tx_byte = {r_dev, 1'b1};
        endcase
        w_scl = r_q[1];
        w_sda = w_tx_byte[r_bit];
        if (w_byte_end) begin
          case (r_state)
            ST_DEV_W: w_next = ST_ACK1;
            ST_REG:   w_next = ST_ACK2;
            ST_WDATA: w_next = ST_ACK3;
            default:  w_next = ST_ACK4;
          endcase
        end
      end
      ST_ACK1: begin
        w_scl = r_q[1];
        if (w_slot_end) w_next = w_nack ? ST_STOP : ST_REG;
      end
      ST_ACK2: begin
        w_scl = r_q[1];
        if (w_slot_end) w_next = w_nack ? ST_STOP : (r_rw ? ST_RESTART : ST_WDATA);
      end
      ST_ACK3: begin
        w_scl = r_q[1];
        if (w_slot_end) w_next = ST_STOP;
      end
      ST_RESTART: begin
        w_scl = (r_q == 2'd1) || (r_q == 2'd2);
        w_sda = ~r_q[1];
        if (w_slot_end) w_next = ST_DEV_R;
      end
      ST_ACK4: begin
        w_scl = r_q[1];
        if (w_slot_end) w_next = w_nack ? ST_STOP : ST_RDATA;
      end
      ST_RDATA: begin
        w_scl = r_q[1];
        if (w_byte_end) w_next = ST_MNACK;
      end
      ST_MNACK: begin
        w_scl = r_q[1];
        if (w_slot_end) w_next = ST_STOP;
      end
      ST_STOP: begin
        w_scl = (r_q != 2'd0);
        w_sda = r_q[1];
        if (w_slot_end) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_pre     <= 8'd0;
      r_q       <= 2'd0;
      r_bit     <= 3'd0;
      r_rw      <= 1'b0;
      r_dev     <= 7'd0;
      r_reg     <= 8'd0;
      r_wd      <= 8'd0;
      r_shift   <= 8'd0;
      r_done    <= 1'b0;
      r_ack_err <= 1'b0;
      r_rd      <= 8'd0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == ST_STOP) && w_slot_end;
      if (r_state == ST_IDLE) begin
        r_pre <= 8'd0;
        r_q   <= 2'd0;
        if (start) begin
          r_bit     <= 3'd7;
          r_rw      <= rw;
          r_dev     <= dev_addr;
          r_reg     <= reg_addr;
          r_wd      <= wr_data;
          r_ack_err <= 1'b0;
        end
      end else begin
        if (w_q_end) begin
          r_pre <= 8'd0;
          r_q   <= r_q + 2'd1;
        end else begin
          r_pre <= r_pre + 8'd1;
        end
        if (w_slot_end)
          r_bit <= (w_bit_state && (r_bit != 3'd0)) ? r_bit - 3'd1 : 3'd7;
        if (w_sample && w_ack_state && sda_in)
          r_ack_err <= 1'b1;
        if (w_sample && (r_state == ST_RDATA))
          r_shift <= {r_shift[6:0], sda_in};
        if ((r_state == ST_STOP) && w_slot_end && r_rw && !r_ack_err)
          r_rd <= r_shift;
      end
    end
  end

  assign scl     = w_scl;
  assign sda_out = w_sda;
  assign busy    = (r_state != ST_IDLE);
  assign done    = r_done;
  assign ack_err = r_ack_err;
  assign rd_data = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_i2c_master_ctrl
// Purpose  : randomized bench; a slot-list model predicts every output cycle
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_master_ctrl;

  localparam int K_START = 0, K_WBIT = 1, K_ACK = 2, K_RBIT = 3, K_RESTART = 4, K_STOP = 5;

  typedef struct packed {
    logic       scl;
    logic       sda;
    logic       busy;
    logic       done;
    logic       chk;
    logic       ack_err;
    logic [7:0] rd;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst_w, start_w, rw_w, sdai_w, scl_w, sdao_w, busy_w, done_w, aerr_w;
  logic [1:0][6:0] dev_w;
  logic [1:0][7:0] reg_w, wd_w, rd_w;

  i2c_master_ctrl #(.CLK_DIV(2)) u_dut_div2 (
    .clk(clk), .rst(rst_w[0]), .start(start_w[0]), .rw(rw_w[0]),
    .dev_addr(dev_w[0]), .reg_addr(reg_w[0]), .wr_data(wd_w[0]),
    .scl(scl_w[0]), .sda_out(sdao_w[0]), .sda_in(sdai_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .ack_err(aerr_w[0]), .rd_data(rd_w[0])
  );

  i2c_master_ctrl #(.CLK_DIV(1)) u_dut_div1 (
    .clk(clk), .rst(rst_w[1]), .start(start_w[1]), .rw(rw_w[1]),
    .dev_addr(dev_w[1]), .reg_addr(reg_w[1]), .wr_data(wd_w[1]),
    .scl(scl_w[1]), .sda_out(sdao_w[1]), .sda_in(sdai_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .ack_err(aerr_w[1]), .rd_data(rd_w[1])
  );

  exp_t            expq0[$], expq1[$];
  int              kinds[$];
  logic            vals[$];
  logic [1:0]      m_ack;
  logic [1:0][7:0] m_rd;
  int              m_len;
  int              n_checks = 0, n_errors = 0;

  logic [1:0]      prev_scl, prev_sda, prev_busy;
  int              nbusy[2], lat[2], ncap[2], nhold[2];
  logic            cap[2][64];

  task automatic chk(input string name, input int s, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (dut %0d) at %0t: got %0h, expected %0h", name, s, $time, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic sc, input logic sd, input logic bz, input logic dn,
                              input logic ck, input logic ae, input logic [7:0] rd);
    exp_t e;
    e.scl = sc; e.sda = sd; e.busy = bz; e.done = dn; e.chk = ck; e.ack_err = ae; e.rd = rd;
    return e;
  endfunction

  function automatic logic [7:0] cap_byte(input int s, input int i);
    logic [7:0] r;
    r = 8'h00;
    for (int b = 0; b < 8; b++) r = {r[6:0], cap[s][i + b]};
    return r;
  endfunction

  // Per-quarter bus waveforms, bit index = quarter number.
  task automatic slot_wave(input int kind, input logic v, input int q, output logic sc, output logic sd);
    logic [3:0] ts, td;
    case (kind)
      K_START:   begin ts = 4'b1111; td = 4'b0011; end
      K_RESTART: begin ts = 4'b0110; td = 4'b0011; end
      K_STOP:    begin ts = 4'b1110; td = 4'b1100; end
      K_WBIT:    begin ts = 4'b1100; td = {4{v}};  end
      default:   begin ts = 4'b1100; td = 4'b1111; end
    endcase
    sc = ts[q];
    sd = td[q];
  endtask

  task automatic push_slot(input int kind, input logic v);
    kinds.push_back(kind);
    vals.push_back(v);
  endtask

  task automatic push_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) push_slot(K_WBIT, v[i]);
  endtask

  task automatic step(input int s, input exp_t e);
    if (s == 0) expq0.push_back(e); else expq1.push_back(e);
    @(posedge clk); #1;
  endtask

  // One request: build the slot list, then walk it cycle by cycle.
  task automatic run_txn(input int s, input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [7:0] wd, input logic [3:0] nack, input logic [7:0] rbyte,
                         input int abort_at);
    int   d, k, j, q, len;
    logic sc, sd, fail;
    d = (s == 0) ? 2 : 1;
    kinds.delete();
    vals.delete();
    push_slot(K_START, 1'b0);
    push_byte({dev, 1'b0});
    push_slot(K_ACK, nack[0]);
    fail = nack[0];
    if (!fail) begin
      push_byte(rg);
      push_slot(K_ACK, nack[1]);
      fail = nack[1];
      if (!fail && !rw) begin
        push_byte(wd);
        push_slot(K_ACK, nack[2]);
        fail = nack[2];
      end else if (!fail) begin
        push_slot(K_RESTART, 1'b0);
        push_byte({dev, 1'b1});
        push_slot(K_ACK, nack[3]);
        fail = nack[3];
        if (!fail) begin
          for (int i = 7; i >= 0; i--) push_slot(K_RBIT, rbyte[i]);
          push_slot(K_WBIT, 1'b1);
        end
      end
    end
    push_slot(K_STOP, 1'b0);
    len   = kinds.size() * 4 * d;
    m_len = len;

    rw_w[s] = rw; dev_w[s] = dev; reg_w[s] = rg; wd_w[s] = wd; start_w[s] = 1'b1;
    step(s, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, m_ack[s], m_rd[s]));
    for (int c = 1; c <= len; c++) begin
      k = (c - 1) / (4 * d);
      j = (c - 1) % (4 * d);
      q = j / d;
      slot_wave(kinds[k], vals[k], q, sc, sd);
      // Only the sampling cycle carries the real responder bit; noise elsewhere.
      if (j == 3 * d && (kinds[k] == K_ACK || kinds[k] == K_RBIT)) sdai_w[s] = vals[k];
      else sdai_w[s] = 1'($urandom);
      start_w[s] = ($urandom_range(0, 15) == 0);
      rw_w[s]    = 1'($urandom);
      dev_w[s]   = 7'($urandom);
      reg_w[s]   = 8'($urandom);
      wd_w[s]    = 8'($urandom);
      if (c == abort_at) rst_w[s] = 1'b0;
      step(s, mk(sc, sd, 1'b1, 1'b0, 1'b0, 1'b0, m_rd[s]));
      if (c == abort_at) begin
        rst_w[s]   = 1'b1;
        start_w[s] = 1'b0;
        m_ack[s]   = 1'b0;
        m_rd[s]    = 8'h00;
        step(s, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00));
        step(s, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00));
        return;
      end
    end
    start_w[s] = 1'b0;
    m_ack[s]   = fail;
    if (rw && !fail) m_rd[s] = rbyte;
    step(s, mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, m_ack[s], m_rd[s]));
    step(s, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, m_ack[s], m_rd[s]));
  endtask

  always @(negedge clk) begin : compare
    exp_t e;
    logic have;
    for (int s = 0; s < 2; s++) begin
      have = 1'b0;
      if (s == 0 && expq0.size() > 0) begin e = expq0.pop_front(); have = 1'b1; end
      else if (s == 1 && expq1.size() > 0) begin e = expq1.pop_front(); have = 1'b1; end
      if (have) begin
        chk("scl", s, 32'(scl_w[s]), 32'(e.scl));
        chk("sda_out", s, 32'(sdao_w[s]), 32'(e.sda));
        chk("busy", s, 32'(busy_w[s]), 32'(e.busy));
        chk("done", s, 32'(done_w[s]), 32'(e.done));
        chk("rd_data", s, 32'(rd_w[s]), 32'(e.rd));
        if (e.chk) chk("ack_err", s, 32'(aerr_w[s]), 32'(e.ack_err));
      end
      if (busy_w[s] && !prev_busy[s]) begin nbusy[s] = 0; ncap[s] = 0; nhold[s] = 0; end
      if (busy_w[s]) nbusy[s]++;
      if (done_w[s]) lat[s] = nbusy[s];
      if (busy_w[s] && !prev_scl[s] && scl_w[s] && ncap[s] < 64) begin
        cap[s][ncap[s]] = sdao_w[s];
        ncap[s]++;
      end
      if (prev_scl[s] && scl_w[s] && (prev_sda[s] != sdao_w[s])) nhold[s]++;
      prev_scl[s]  = scl_w[s];
      prev_sda[s]  = sdao_w[s];
      prev_busy[s] = busy_w[s];
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] nk;
    int         s, ab;
    rst_w = 2'b00; start_w = 2'b00; rw_w = 2'b00; sdai_w = 2'b11;
    dev_w = '0; reg_w = '0; wd_w = '0;
    m_ack = 2'b00; m_rd = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_w = 2'b11;
    expq1.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00));
    step(0, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00));

    run_txn(0, 1'b0, 7'h7F, 8'hA5, 8'h3C, 4'b0000, 8'h00, 0);
    chk("model_write_len", 0, 32'(m_len), 32'd232);
    chk("write_latency", 0, 32'(lat[0]), 32'd232);
    chk("write_dev_byte", 0, 32'(cap_byte(0, 0)), 32'hFE);
    chk("write_reg_byte", 0, 32'(cap_byte(0, 9)), 32'hA5);
    chk("write_data_byte", 0, 32'(cap_byte(0, 18)), 32'h3C);
    chk("write_scl_rises", 0, 32'(ncap[0]), 32'd28);

    run_txn(0, 1'b0, 7'h12, 8'h34, 8'h56, 4'b0001, 8'h00, 0);
    chk("nack1_latency", 0, 32'(lat[0]), 32'd88);
    chk("nack1_scl_rises", 0, 32'(ncap[0]), 32'd10);
    chk("nack1_ack_err", 0, 32'(aerr_w[0]), 32'd1);

    run_txn(0, 1'b1, 7'h50, 8'h10, 8'h00, 4'b0000, 8'h96, 0);
    chk("model_read_len", 0, 32'(m_len), 32'd312);
    chk("read_latency", 0, 32'(lat[0]), 32'd312);
    chk("read_devw_byte", 0, 32'(cap_byte(0, 0)), 32'hA0);
    chk("read_reg_byte", 0, 32'(cap_byte(0, 9)), 32'h10);
    chk("read_restart_sda", 0, 32'(cap[0][18]), 32'd1);
    chk("read_devr_byte", 0, 32'(cap_byte(0, 19)), 32'hA1);
    chk("read_mnack_sda", 0, 32'(cap[0][36]), 32'd1);
    chk("read_rd_data", 0, 32'(rd_w[0]), 32'h96);

    // Abort in REG bit 3 (slot 14), then a complete read must still work.
    run_txn(0, 1'b0, 7'h2A, 8'hC3, 8'h81, 4'b0000, 8'h00, 14 * 8 + 3);
    chk("abort_rd_data", 0, 32'(rd_w[0]), 32'h00);
    run_txn(0, 1'b1, 7'h33, 8'h44, 8'h00, 4'b0000, 8'h5A, 0);
    chk("after_abort_rd_data", 0, 32'(rd_w[0]), 32'h5A);

    run_txn(1, 1'b0, 7'h7F, 8'hA5, 8'h3C, 4'b0000, 8'h00, 0);
    chk("div1_latency", 1, 32'(lat[1]), 32'd116);
    chk("div1_sda_moves_scl_high", 1, 32'(nhold[1]), 32'd2);

    for (int n = 0; n < 20; n++) begin
      s = n % 2;
      for (int b = 0; b < 4; b++) nk[b] = ($urandom_range(0, 9) == 0);
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 40)) : 0;
      run_txn(s, 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), nk, 8'($urandom), ab);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
